tdr_bank: RTL and testbench
===========================

Name: tdr_bank

Overview:
- Parametrised JTAG test-data-register bank: NUM registers of WIDTH bits behind a single shared capture/shift path, selected by an instruction-decoder index.
- Each register is read-write (captures its own update latch) or read-only (captures an external status bus), set per register by a mask.
- Adds a shift-length check: an update is committed only if exactly WIDTH shifts occurred since the last capture. A sticky error flag is raised otherwise.
- Sits between the TAP controller/IR decoder and the on-chip configuration/status logic.

Parameters:
- WIDTH, 17, bits per data register (>=2).
- NUM, 4, number of data registers (>=1).
- SELW, 2, width of Sel; must satisfy 2**SELW >= NUM.
- RO_MASK, 4'b1000, bit i=1 makes register i read-only; NUM bits wide.

Ports:
- TCLK  in  1  test clock; shift on rising edge, update on falling edge.
- TRESETN  in  1  asynchronous active-low reset.
- CaptureDR  in  1  TAP Capture-DR state.
- ShiftDR  in  1  TAP Shift-DR state.
- UpdateDR  in  1  TAP Update-DR state.
- Enable  in  1  bank selected by IR decode.
- Sel  in  SELW  register index; stable from Capture-DR through Update-DR.
- SI  in  1  serial input (TDI).
- CapData  in  NUM*WIDTH  parallel capture sources; slice i is used when RO_MASK[i]=1.
- UpdData  out  NUM*WIDTH  update latches, slice i = register i.
- UpdStrobe  out  NUM  bit i pulses when register i is updated.
- LenErr  out  1  sticky shift-length error.
- SO  out  1  serial output (TDO path).

Behaviour:
- Reset (TRESETN=0, async): shift register, all UpdData slices, shift counter, UpdStrobe, LenErr and SO all go to 0.
- Shift register (rising TCLK), priority order:
  1. ShiftDR&&Enable: shift right, SI enters the MSB, and the counter increments, saturating at WIDTH+1.
  2. CaptureDR&&Enable: load the capture source for Sel and clear the counter.
     - RO register: source is CapData slice Sel.
     - RW register: source is UpdData slice Sel.
     - Sel>=NUM: source is all-zeros.
  3. Otherwise: hold.
- A counter of width clog2(WIDTH+2) tracks shifts.
- Update (falling TCLK) when UpdateDR&&Enable:
  - Counter==WIDTH, Sel<NUM and RO_MASK[Sel]=0: UpdData slice Sel <= shift register; UpdStrobe[Sel]=1 for one full TCLK period (until the next falling edge); other slices unchanged.
  - Counter!=WIDTH and Sel<NUM: no write and no strobe; LenErr <= 1. This applies to RO registers too.
  - RO register with correct length: no write, no strobe, no error.
  - Sel>=NUM: update ignored; LenErr unaffected.
- UpdStrobe bits otherwise clear on every falling edge.
- LenErr clears on rising TCLK when CaptureDR&&Enable (a new scan begins) or on reset. An error and a clear never coincide because they occur on opposite edges.
- SO = shift register bit 0 when Enable, else 0 (combinational in base build).
- Enable low: no shift, capture, update or counting; all state holds.
- Reset mid-scan: all state clears immediately; a following UpdateDR without capture/shift sees counter 0 and flags LenErr.
- Zero-shift scan (Capture then Update): the update is suppressed and LenErr is set.
- Over-length scan (WIDTH+k shifts, k>=1): the counter saturates at WIDTH+1, the update is suppressed and LenErr is set.

Optional Feature:
- Macro: TDR_SO_RETIME_EN.
- Defined: SO is registered on falling TCLK from (Enable ? shift[0] : 0), matching IEEE 1149.1 TDO timing; the registered SO resets to 0. SO changes half a cycle after the shift edge.
- Undefined: SO is combinational as described above.

Decomposition:
- Shared package tdr_pkg holds:
  - localparams for default WIDTH/NUM;
  - the function clog2;
  - the counter-width constant expression;
  - a typedef/enum for register mode (TDR_RW=0, TDR_RO=1).
- Natural sub-module: tdr_upd_latch, one WIDTH-bit falling-edge update latch with write-enable and strobe, instantiated NUM times via generate.
- The shift path, counter and error logic stay in the top.

Test Plan:
- Reset: hold TRESETN=0 mid-shift -> UpdData=0, UpdStrobe=0, LenErr=0, SO=0; after release, Capture on Sel=0 shifts out 17 zeros.
- RW write/readback:
  - Sel=1, Capture, shift 17 bits of 0x1A5A5, Update -> UpdData[1]=0x1A5A5, UpdStrobe=4'b0010 for one period, LenErr=0.
  - Re-Capture and shift -> SO emits 0x1A5A5 LSB first.
- RO capture: CapData[3]=0x0BEEF, Sel=3, Capture, shift 17 -> SO streams 0x0BEEF LSB first; Update -> UpdData[3] stays 0, no strobe, no error.
- Length errors:
  - Sel=2, Capture, shift 16, Update -> UpdData[2] unchanged, LenErr=1.
  - Next Capture with Enable -> LenErr=0.
  - Repeat with 18 shifts -> same result.
- Enable gating: Enable=0 through a full Capture/17-shift/Update on Sel=0 -> no state change, SO=0; Sel=3'd out-of-range (SELW=3, NUM=4) with Sel=5 -> capture zeros, update ignored, LenErr unchanged.
- TDR_SO_RETIME_EN: same RW scan -> SO transitions aligned to falling TCLK, one half-cycle after the shift edge; reset forces SO=0.

Source files
------------

// File: rtl/tdr_pkg.sv
// Shared definitions for the JTAG test-data-register bank: defaults, counter sizing,
// and the per-register access mode.
package tdr_pkg;

    localparam int unsigned TdrWidthDef = 17;
    localparam int unsigned TdrNumDef   = 4;

    typedef enum logic {
        TDR_RW = 1'b0,
        TDR_RO = 1'b1
    } tdr_mode_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r = 0;
        while ((64'd1 << r) < 64'(n)) r++;
        return r;
    endfunction

    // Shift counter must represent 0..WIDTH+1 (saturation value flags over-length).
    function automatic int unsigned tdr_cnt_w(input int unsigned width);
        return clog2(width + 2);
    endfunction

    localparam int unsigned TdrCntWDef = tdr_cnt_w(TdrWidthDef);

endpackage

// File: rtl/tdr_upd_latch.sv
// One falling-edge update latch for a test-data register, with a one-period write strobe.
module tdr_upd_latch #(
    parameter int unsigned WIDTH = 17
) (
    input  logic             tck_i,
    input  logic             trst_ni,
    input  logic             we_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o,
    output logic             strobe_o
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             strobe_q;

    always_comb begin
        q_d = q_q;
        if (we_i) q_d = d_i;
    end

    always_ff @(negedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            q_q      <= '0;
            strobe_q <= 1'b0;
        end else begin
            q_q      <= q_d;
            strobe_q <= we_i;
        end
    end

    assign q_o      = q_q;
    assign strobe_o = strobe_q;

endmodule

// File: rtl/tdr_bank.sv
// JTAG test-data-register bank with shared shift path and shift-length checking.
// Define TDR_SO_RETIME_EN to register SO on falling TCLK.
module tdr_bank
    import tdr_pkg::*;
#(
    parameter int unsigned    WIDTH   = TdrWidthDef,
    parameter int unsigned    NUM     = TdrNumDef,
    parameter int unsigned    SELW    = 2,
    parameter logic [NUM-1:0] RO_MASK = NUM'(4'b1000)
) (
    input  logic                 TCLK,
    input  logic                 TRESETN,
    input  logic                 CaptureDR,
    input  logic                 ShiftDR,
    input  logic                 UpdateDR,
    input  logic                 Enable,
    input  logic [SELW-1:0]      Sel,
    input  logic                 SI,
    input  logic [NUM*WIDTH-1:0] CapData,
    output logic [NUM*WIDTH-1:0] UpdData,
    output logic [NUM-1:0]       UpdStrobe,
    output logic                 LenErr,
    output logic                 SO
);

    localparam int unsigned    CntW    = tdr_cnt_w(WIDTH);
    localparam logic [CntW-1:0] CntFull = CntW'(WIDTH);
    localparam logic [CntW-1:0] CntSat  = CntW'(WIDTH + 1);

    logic [WIDTH-1:0] shift_q, shift_d, cap_src;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             sel_valid;
    tdr_mode_e        sel_mode;
    logic [NUM-1:0]   upd_we;
    logic             upd_ok, len_bad, cap_clr;
    logic             err_p_q, err_p_d, err_n_q, err_n_d;

    always_comb begin
        cap_src   = '0;
        sel_valid = 1'b0;
        sel_mode  = TDR_RW;
        for (int i = 0; i < int'(NUM); i++) begin
            if (int'(Sel) == i) begin
                sel_valid = 1'b1;
                sel_mode  = tdr_mode_e'(RO_MASK[i]);
                cap_src   = RO_MASK[i] ? CapData[i*WIDTH +: WIDTH] : UpdData[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (ShiftDR && Enable) begin
            shift_d = {SI, shift_q[WIDTH-1:1]};
            if (cnt_q != CntSat) cnt_d = cnt_q + 1'b1;
        end else if (CaptureDR && Enable) begin
            shift_d = cap_src;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge TCLK or negedge TRESETN) begin
        if (!TRESETN) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign upd_ok  = UpdateDR && Enable && sel_valid && (cnt_q == CntFull) && (sel_mode == TDR_RW);
    assign len_bad = UpdateDR && Enable && sel_valid && (cnt_q != CntFull);
    assign cap_clr = CaptureDR && Enable;

    always_comb begin
        upd_we = '0;
        for (int i = 0; i < int'(NUM); i++) begin
            if (int'(Sel) == i && upd_ok) upd_we[i] = 1'b1;
        end
    end

    // LenErr is set on falling TCLK and cleared on rising TCLK; one flop per edge, XORed.
    always_comb begin
        err_n_d = len_bad ? ~err_p_q : err_n_q;
        err_p_d = cap_clr ? err_n_q : err_p_q;
    end

    always_ff @(negedge TCLK or negedge TRESETN) begin
        if (!TRESETN) err_n_q <= 1'b0;
        else          err_n_q <= err_n_d;
    end

    always_ff @(posedge TCLK or negedge TRESETN) begin
        if (!TRESETN) err_p_q <= 1'b0;
        else          err_p_q <= err_p_d;
    end

    assign LenErr = err_p_q ^ err_n_q;

    for (genvar g = 0; g < int'(NUM); g++) begin : g_latch
        tdr_upd_latch #(
            .WIDTH(WIDTH)
        ) u_latch (
            .tck_i   (TCLK),
            .trst_ni (TRESETN),
            .we_i    (upd_we[g]),
            .d_i     (shift_q),
            .q_o     (UpdData[g*WIDTH +: WIDTH]),
            .strobe_o(UpdStrobe[g])
        );
    end

`ifdef TDR_SO_RETIME_EN
    logic so_q, so_d;

    assign so_d = Enable ? shift_q[0] : 1'b0;

    always_ff @(negedge TCLK or negedge TRESETN) begin
        if (!TRESETN) so_q <= 1'b0;
        else          so_q <= so_d;
    end

    assign SO = so_q;
`else
    assign SO = Enable ? shift_q[0] : 1'b0;
`endif

endmodule

// File: tb/tb_tdr_bank.sv
// Directed, table-driven bench for tdr_bank (WIDTH=17, NUM=4, SELW=3, RO_MASK=4'b1000).
module tb_tdr_bank;

    localparam int unsigned W = 17;
    localparam int unsigned N = 4;

    logic           TCLK = 1'b0;
    logic           TRESETN;
    logic           CaptureDR, ShiftDR, UpdateDR, Enable, SI;
    logic [2:0]     Sel;
    logic [N*W-1:0] CapData;
    logic [N*W-1:0] UpdData;
    logic [N-1:0]   UpdStrobe;
    logic           LenErr, SO;

    int n_cmp = 0;
    int n_bad = 0;

    tdr_bank #(
        .WIDTH  (W),
        .NUM    (N),
        .SELW   (3),
        .RO_MASK(4'b1000)
    ) dut (
        .TCLK     (TCLK),
        .TRESETN  (TRESETN),
        .CaptureDR(CaptureDR),
        .ShiftDR  (ShiftDR),
        .UpdateDR (UpdateDR),
        .Enable   (Enable),
        .Sel      (Sel),
        .SI       (SI),
        .CapData  (CapData),
        .UpdData  (UpdData),
        .UpdStrobe(UpdStrobe),
        .LenErr   (LenErr),
        .SO       (SO)
    );

    always #5 TCLK = ~TCLK;

    typedef struct {
        logic [2:0]     sel;
        logic           en;
        int             n;
        logic [W-1:0]   data;
        logic           chk_so;
        logic [W-1:0]   exp_so;
        logic           exp_err_cap;
        logic [N*W-1:0] exp_upd;
        logic [N-1:0]   exp_stb;
        logic           exp_err;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after a falling edge; outputs are sampled there too.
    task automatic tick();
        @(posedge TCLK);
        @(negedge TCLK);
        #1;
    endtask

    task automatic scan(input vec_t v, output logic [W-1:0] so_word, output logic err_cap);
        so_word   = '0;
        Enable    = v.en;
        Sel       = v.sel;
        CaptureDR = 1'b1;
        tick();
        CaptureDR = 1'b0;
        err_cap   = LenErr;
        for (int k = 0; k < v.n; k++) begin
            if (k < int'(W)) so_word[k] = SO;
            ShiftDR = 1'b1;
            SI      = (k < int'(W)) ? v.data[k] : 1'b0;
            tick();
        end
        ShiftDR  = 1'b0;
        SI       = 1'b0;
        UpdateDR = 1'b1;
        tick();
        UpdateDR = 1'b0;
    endtask

    logic [W-1:0] so_word;
    logic         err_cap;

    initial begin
        TRESETN   = 1'b0;
        CaptureDR = 1'b0;
        ShiftDR   = 1'b0;
        UpdateDR  = 1'b0;
        Enable    = 1'b0;
        SI        = 1'b0;
        Sel       = '0;
        CapData   = {17'h0BEEF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF};

        vecs[0]  = '{3'd0, 1'b1, 17, 17'h13579, 1'b1, 17'h00000, 1'b0,
                     {17'h0, 17'h0, 17'h0, 17'h13579}, 4'b0001, 1'b0};
        vecs[1]  = '{3'd1, 1'b1, 17, 17'h1A5A5, 1'b1, 17'h00000, 1'b0,
                     {17'h0, 17'h0, 17'h1A5A5, 17'h13579}, 4'b0010, 1'b0};
        vecs[2]  = '{3'd1, 1'b1, 17, 17'h00F0F, 1'b1, 17'h1A5A5, 1'b0,
                     {17'h0, 17'h0, 17'h00F0F, 17'h13579}, 4'b0010, 1'b0};
        vecs[3]  = '{3'd3, 1'b1, 17, 17'h15555, 1'b1, 17'h0BEEF, 1'b0,
                     {17'h0, 17'h0, 17'h00F0F, 17'h13579}, 4'b0000, 1'b0};
        vecs[4]  = '{3'd2, 1'b1, 16, 17'h1FFFF, 1'b0, 17'h00000, 1'b0,
                     {17'h0, 17'h0, 17'h00F0F, 17'h13579}, 4'b0000, 1'b1};
        vecs[5]  = '{3'd2, 1'b1, 18, 17'h1FFFF, 1'b0, 17'h00000, 1'b0,
                     {17'h0, 17'h0, 17'h00F0F, 17'h13579}, 4'b0000, 1'b1};
        vecs[6]  = '{3'd0, 1'b0, 17, 17'h1ABCD, 1'b1, 17'h00000, 1'b1,
                     {17'h0, 17'h0, 17'h00F0F, 17'h13579}, 4'b0000, 1'b1};
        vecs[7]  = '{3'd5, 1'b1, 17, 17'h12345, 1'b1, 17'h00000, 1'b0,
                     {17'h0, 17'h0, 17'h00F0F, 17'h13579}, 4'b0000, 1'b0};
        vecs[8]  = '{3'd3, 1'b1, 16, 17'h00001, 1'b0, 17'h00000, 1'b0,
                     {17'h0, 17'h0, 17'h00F0F, 17'h13579}, 4'b0000, 1'b1};
        vecs[9]  = '{3'd5, 1'b1, 16, 17'h00001, 1'b0, 17'h00000, 1'b0,
                     {17'h0, 17'h0, 17'h00F0F, 17'h13579}, 4'b0000, 1'b0};
        vecs[10] = '{3'd2, 1'b1, 17, 17'h0AAAA, 1'b1, 17'h00000, 1'b0,
                     {17'h0, 17'h0AAAA, 17'h00F0F, 17'h13579}, 4'b0100, 1'b0};
        vecs[11] = '{3'd2, 1'b1, 17, 17'h00000, 1'b1, 17'h0AAAA, 1'b0,
                     {17'h0, 17'h0, 17'h00F0F, 17'h13579}, 4'b0100, 1'b0};

        #12;
        chk("reset UpdData", 128'(UpdData), 128'(0));
        chk("reset UpdStrobe", 128'(UpdStrobe), 128'(0));
        chk("reset LenErr", 128'(LenErr), 128'(0));
        chk("reset SO", 128'(SO), 128'(0));
        @(negedge TCLK);
        #1;
        TRESETN = 1'b1;

        for (int i = 0; i < 12; i++) begin
            scan(vecs[i], so_word, err_cap);
            chk($sformatf("v%0d LenErr after capture", i), 128'(err_cap), 128'(vecs[i].exp_err_cap));
            if (vecs[i].chk_so)
                chk($sformatf("v%0d SO stream", i), 128'(so_word), 128'(vecs[i].exp_so));
            chk($sformatf("v%0d UpdData", i), 128'(UpdData), 128'(vecs[i].exp_upd));
            chk($sformatf("v%0d UpdStrobe", i), 128'(UpdStrobe), 128'(vecs[i].exp_stb));
            chk($sformatf("v%0d LenErr", i), 128'(LenErr), 128'(vecs[i].exp_err));
            tick();
            chk($sformatf("v%0d UpdStrobe cleared", i), 128'(UpdStrobe), 128'(0));
        end

        // Set LenErr, then reset in the middle of a shift on a nonzero register.
        Enable    = 1'b1;
        Sel       = 3'd1;
        CaptureDR = 1'b1;
        tick();
        CaptureDR = 1'b0;
        ShiftDR   = 1'b1;
        SI        = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        ShiftDR  = 1'b0;
        UpdateDR = 1'b1;
        tick();
        UpdateDR = 1'b0;
        chk("short scan LenErr", 128'(LenErr), 128'(1));
        CaptureDR = 1'b1;
        tick();
        CaptureDR = 1'b0;
        ShiftDR   = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        TRESETN = 1'b0;
        #2;
        chk("mid-scan reset UpdData", 128'(UpdData), 128'(0));
        chk("mid-scan reset UpdStrobe", 128'(UpdStrobe), 128'(0));
        chk("mid-scan reset LenErr", 128'(LenErr), 128'(0));
        chk("mid-scan reset SO", 128'(SO), 128'(0));
        ShiftDR = 1'b0;
        SI      = 1'b0;
        TRESETN = 1'b1;
        @(negedge TCLK);
        #1;
        // Update with no capture/shift after reset: counter is 0, so length error.
        UpdateDR = 1'b1;
        tick();
        UpdateDR = 1'b0;
        chk("post-reset update LenErr", 128'(LenErr), 128'(1));
        chk("post-reset update UpdData", 128'(UpdData), 128'(0));
        chk("post-reset update UpdStrobe", 128'(UpdStrobe), 128'(0));

        // Zero-shift scan on a RW register.
        CaptureDR = 1'b1;
        tick();
        CaptureDR = 1'b0;
        chk("zero-shift capture clears LenErr", 128'(LenErr), 128'(0));
        UpdateDR = 1'b1;
        tick();
        UpdateDR = 1'b0;
        chk("zero-shift LenErr", 128'(LenErr), 128'(1));
        chk("zero-shift UpdStrobe", 128'(UpdStrobe), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
